// File: rtl/bingo_pick_commit.sv
// Validates a two-digit BCD entry as a Bingo call, offers good calls over valid/ready
// and records committed calls in a bitmap; bad entries produce a coded reject pulse.
//
// state   | meaning
// IDLE    | waiting for enter_pulse; entry register loads on it
// CHECK   | one cycle: range, BCD and duplicate check of the latched entry
// OFFER   | pick_valid held until pick_ready; further entries get a busy reject
module bingo_pick_commit #(
  parameter int MAX_NUM = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         display_num,
  input  logic               enter_pulse,
  input  logic               clear_called,
  input  logic               pick_ready,
  output logic               pick_valid,
  output logic [6:0]         pick_num,
  output logic               reject_pulse,
  output logic [1:0]         reject_code,
  output logic [MAX_NUM-1:0] called_map,
  output logic [6:0]         called_count,
  output logic               all_called
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;

  localparam logic [1:0] CODE_RANGE = 2'b01;
  localparam logic [1:0] CODE_DUP   = 2'b10;
  localparam logic [1:0] CODE_BUSY  = 2'b11;

  localparam logic [6:0]         MAX7    = 7'(MAX_NUM);
  localparam logic [MAX_NUM-1:0] MAP_ONE = {{(MAX_NUM-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [7:0]         entry;
  logic [3:0]         tens;
  logic [3:0]         ones;
  logic [6:0]         value;
  logic               bad_entry;
  logic               is_dup;
  logic [MAX_NUM-1:0] check_bit;
  logic [MAX_NUM-1:0] commit_bit;

  assign tens  = entry[7:4];
  assign ones  = entry[3:0];
  // tens*10 as tens*8 + tens*2, kept 7 bits wide
  assign value = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};

  assign bad_entry  = (tens > 4'd9) || (ones > 4'd9) || (value == 7'd0) || (value > MAX7);
  assign check_bit  = MAP_ONE << (value - 7'd1);
  assign is_dup     = |(called_map & check_bit);
  assign commit_bit = MAP_ONE << (pick_num - 7'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      entry        <= '0;
      pick_valid   <= 1'b0;
      pick_num     <= '0;
      reject_pulse <= 1'b0;
      reject_code  <= '0;
      called_map   <= '0;
      called_count <= '0;
      all_called   <= 1'b0;
    end else begin
      reject_pulse <= 1'b0;
      if (clear_called) begin
        state        <= S_IDLE;
        pick_valid   <= 1'b0;
        called_map   <= '0;
        called_count <= '0;
        all_called   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enter_pulse) begin
              entry <= display_num;
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (bad_entry) begin
              reject_pulse <= 1'b1;
              reject_code  <= CODE_RANGE;
              state        <= S_IDLE;
            end else if (is_dup) begin
              reject_pulse <= 1'b1;
              reject_code  <= CODE_DUP;
              state        <= S_IDLE;
            end else begin
              pick_valid <= 1'b1;
              pick_num   <= value;
              state      <= S_OFFER;
            end
          end
          S_OFFER: begin
            if (enter_pulse) begin
              reject_pulse <= 1'b1;
              reject_code  <= CODE_BUSY;
            end
            if (pick_ready) begin
              called_map   <= called_map | commit_bit;
              called_count <= called_count + 7'd1;
              all_called   <= (called_count == MAX7 - 7'd1);
              pick_valid   <= 1'b0;
              state        <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bingo_pick_commit.sv
// Directed bench for bingo_pick_commit: inputs change and outputs are sampled on the
// falling clock edge; each task owns its scenario and inline comparisons.
module tb_bingo_pick_commit;

  localparam int MAX_NUM = 25;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         display_num = '0;
  logic               enter_pulse = 1'b0;
  logic               clear_called = 1'b0;
  logic               pick_ready = 1'b0;
  logic               pick_valid;
  logic [6:0]         pick_num;
  logic               reject_pulse;
  logic [1:0]         reject_code;
  logic [MAX_NUM-1:0] called_map;
  logic [6:0]         called_count;
  logic               all_called;

  int checks = 0;
  int failures = 0;

  bingo_pick_commit #(.MAX_NUM(MAX_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .display_num(display_num), .enter_pulse(enter_pulse),
    .clear_called(clear_called), .pick_ready(pick_ready), .pick_valid(pick_valid),
    .pick_num(pick_num), .reject_pulse(reject_pulse), .reject_code(reject_code),
    .called_map(called_map), .called_count(called_count), .all_called(all_called)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse enter for one cycle starting now; returns in cycle 2 of that entry.
  task automatic enter(input logic [7:0] v);
    display_num = v;
    enter_pulse = 1'b1;
    step();
    enter_pulse = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear_called = 1'b1;
    step();
    clear_called = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({pick_valid, pick_num, reject_pulse, reject_code, called_map, called_count, all_called} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {pick_valid, pick_num, reject_pulse, reject_code, called_map, called_count, all_called});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_accept();
    pick_ready = 1'b1;
    enter(8'h07);
    checks++;
    if (pick_valid !== 1'b1 || pick_num !== 7'd7 || reject_pulse !== 1'b0) begin
      failures++;
      $display("FAIL accept_offer got v=%0b n=%0d r=%0b exp v=1 n=7 r=0", pick_valid, pick_num, reject_pulse);
    end
    step();
    checks++;
    if (called_map !== 25'h0000040 || called_count !== 7'd1 || pick_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept_commit got map=%0h cnt=%0d v=%0b exp map=40 cnt=1 v=0", called_map, called_count, pick_valid);
    end
  endtask

  task automatic test_range();
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'h26; vals[2] = 8'h3A;
    for (int i = 0; i < 3; i++) begin
      enter(vals[i]);
      checks++;
      if (reject_pulse !== 1'b1 || reject_code !== 2'b01 || pick_valid !== 1'b0) begin
        failures++;
        $display("FAIL range_reject_%0h got r=%0b c=%0b v=%0b exp r=1 c=01 v=0", vals[i], reject_pulse, reject_code, pick_valid);
      end
      step();
      checks++;
      if (reject_pulse !== 1'b0 || called_map !== 25'h0000040) begin
        failures++;
        $display("FAIL range_after_%0h got r=%0b map=%0h exp r=0 map=40", vals[i], reject_pulse, called_map);
      end
    end
  endtask

  task automatic test_duplicate();
    do_clear();
    pick_ready = 1'b1;
    enter(8'h12);
    step();
    checks++;
    if (called_count !== 7'd1 || called_map !== 25'h0000800) begin
      failures++;
      $display("FAIL dup_first got cnt=%0d map=%0h exp cnt=1 map=800", called_count, called_map);
    end
    enter(8'h12);
    checks++;
    if (reject_pulse !== 1'b1 || reject_code !== 2'b10 || pick_valid !== 1'b0) begin
      failures++;
      $display("FAIL dup_reject got r=%0b c=%0b v=%0b exp r=1 c=10 v=0", reject_pulse, reject_code, pick_valid);
    end
    step();
    checks++;
    if (called_count !== 7'd1) begin
      failures++;
      $display("FAIL dup_count got=%0d exp=1", called_count);
    end
  endtask

  task automatic test_busy();
    do_clear();
    pick_ready = 1'b0;
    enter(8'h05);
    checks++;
    if (pick_valid !== 1'b1 || pick_num !== 7'd5) begin
      failures++;
      $display("FAIL busy_offer got v=%0b n=%0d exp v=1 n=5", pick_valid, pick_num);
    end
    display_num = 8'h09;
    enter_pulse = 1'b1;
    step();
    enter_pulse = 1'b0;
    checks++;
    if (reject_pulse !== 1'b1 || reject_code !== 2'b11 || pick_valid !== 1'b1 || pick_num !== 7'd5) begin
      failures++;
      $display("FAIL busy_reject got r=%0b c=%0b v=%0b n=%0d exp r=1 c=11 v=1 n=5", reject_pulse, reject_code, pick_valid, pick_num);
    end
    step();
    checks++;
    if (reject_pulse !== 1'b0 || pick_valid !== 1'b1 || pick_num !== 7'd5) begin
      failures++;
      $display("FAIL busy_hold got r=%0b v=%0b n=%0d exp r=0 v=1 n=5", reject_pulse, pick_valid, pick_num);
    end
    // handshake and a busy entry in the same cycle
    pick_ready = 1'b1;
    display_num = 8'h09;
    enter_pulse = 1'b1;
    step();
    enter_pulse = 1'b0;
    checks++;
    if (reject_pulse !== 1'b1 || reject_code !== 2'b11 || pick_valid !== 1'b0 ||
        called_map !== 25'h0000010 || called_count !== 7'd1) begin
      failures++;
      $display("FAIL busy_commit got r=%0b c=%0b v=%0b map=%0h cnt=%0d exp r=1 c=11 v=0 map=10 cnt=1",
               reject_pulse, reject_code, pick_valid, called_map, called_count);
    end
    enter(8'h09);
    checks++;
    if (pick_valid !== 1'b1 || pick_num !== 7'd9 || reject_pulse !== 1'b0) begin
      failures++;
      $display("FAIL busy_next_accept got v=%0b n=%0d r=%0b exp v=1 n=9 r=0", pick_valid, pick_num, reject_pulse);
    end
    step();
    checks++;
    if (called_count !== 7'd2 || called_map !== 25'h0000110) begin
      failures++;
      $display("FAIL busy_next_commit got cnt=%0d map=%0h exp cnt=2 map=110", called_count, called_map);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    pick_ready = 1'b1;
    for (int i = 1; i <= MAX_NUM; i++) begin
      enter(8'(((i / 10) << 4) | (i % 10)));
      checks++;
      if (pick_valid !== 1'b1 || pick_num !== 7'(i)) begin
        failures++;
        $display("FAIL b2b_offer_%0d got v=%0b n=%0d exp v=1 n=%0d", i, pick_valid, pick_num, i);
      end
      step();
    end
    checks++;
    if (all_called !== 1'b1 || called_count !== 7'd25 || called_map !== {MAX_NUM{1'b1}}) begin
      failures++;
      $display("FAIL b2b_full got all=%0b cnt=%0d map=%0h exp all=1 cnt=25 map=1ffffff", all_called, called_count, called_map);
    end
    enter(8'h25);
    checks++;
    if (reject_pulse !== 1'b1 || reject_code !== 2'b10) begin
      failures++;
      $display("FAIL full_dup got r=%0b c=%0b exp r=1 c=10", reject_pulse, reject_code);
    end
    step();
    do_clear();
    checks++;
    if (called_map !== '0 || called_count !== 7'd0 || all_called !== 1'b0) begin
      failures++;
      $display("FAIL full_clear got map=%0h cnt=%0d all=%0b exp 0 0 0", called_map, called_count, all_called);
    end
  endtask

  task automatic test_clear_offer();
    pick_ready = 1'b1;
    enter(8'h02);
    step();
    pick_ready = 1'b0;
    enter(8'h03);
    checks++;
    if (pick_valid !== 1'b1 || called_count !== 7'd1) begin
      failures++;
      $display("FAIL clr_setup got v=%0b cnt=%0d exp v=1 cnt=1", pick_valid, called_count);
    end
    clear_called = 1'b1;
    display_num = 8'h04;
    enter_pulse = 1'b1;
    step();
    clear_called = 1'b0;
    enter_pulse = 1'b0;
    checks++;
    if (pick_valid !== 1'b0 || reject_pulse !== 1'b0 || called_count !== 7'd0 || called_map !== '0) begin
      failures++;
      $display("FAIL clr_offer got v=%0b r=%0b cnt=%0d map=%0h exp 0 0 0 0", pick_valid, reject_pulse, called_count, called_map);
    end
    step();
    step();
    checks++;
    if (pick_valid !== 1'b0 || reject_pulse !== 1'b0) begin
      failures++;
      $display("FAIL clr_enter_dropped got v=%0b r=%0b exp v=0 r=0", pick_valid, reject_pulse);
    end
  endtask

  task automatic test_reset_offer();
    pick_ready = 1'b1;
    enter(8'h11);
    step();
    pick_ready = 1'b0;
    enter(8'h06);
    checks++;
    if (pick_valid !== 1'b1 || pick_num !== 7'd6 || called_count !== 7'd1) begin
      failures++;
      $display("FAIL rst_setup got v=%0b n=%0d cnt=%0d exp v=1 n=6 cnt=1", pick_valid, pick_num, called_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pick_valid, pick_num, reject_pulse, reject_code, called_map, called_count, all_called} !== '0) begin
      failures++;
      $display("FAIL rst_mid_offer got=%0h exp=0",
               {pick_valid, pick_num, reject_pulse, reject_code, called_map, called_count, all_called});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_accept();
    test_range();
    test_duplicate();
    test_busy();
    test_back_to_back();
    test_clear_offer();
    test_reset_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bingo_pick_commit.md
# bingo_pick_commit

Downstream stage of the keyboard number-entry handler. It takes the two-digit BCD value and the single-cycle enter strobe, and checks that value as a Bingo call. A call must be a legal BCD number in range 1..MAX_NUM that has not already been called. A valid call is offered to the game logic through a valid/ready handshake, and the block records it in a called-number bitmap. An invalid call produces a one-cycle reject pulse with a reason code.

## Interface
- MAX_NUM, 25: highest callable number; legal range 2..99.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- display_num  in  8  BCD entry; [7:4] is tens, [3:0] is ones. Sampled only on enter_pulse.
- enter_pulse  in  1  single-cycle request to commit display_num.
- clear_called  in  1  synchronous new-game clear.
- pick_ready  in  1  game logic accepts pick_num.
- pick_valid  out  1  a validated call is on offer.
- pick_num  out  7  binary value of the offered call.
- reject_pulse  out  1  one-cycle flag: the entry was refused.
- reject_code  out  2  01 = out of range or non-BCD; 10 = duplicate; 11 = busy. Meaningful only while reject_pulse is high.
- called_map  out  MAX_NUM  bit i-1 is set once number i has been accepted.
- called_count  out  7  number of accepted calls.
- all_called  out  1  high when called_count equals MAX_NUM.

## Operation
- State machine has three states: IDLE, CHECK, OFFER.
- IDLE:
  - enter_pulse latches display_num into the entry register; next state is CHECK.
  - Otherwise the block stays in IDLE.
- CHECK (always exactly one cycle):
  - value = tens*10 + ones, computed 7 bits wide.
  - If either digit is greater than 9, or value is 0, or value is greater than MAX_NUM: register reject_pulse=1 with code 01, then go to IDLE.
  - Else if called_map[value-1] is set: register reject_pulse=1 with code 10, then go to IDLE.
  - Else: register pick_valid=1 and pick_num=value, then go to OFFER.
  - enter_pulse during CHECK is ignored.
- OFFER:
  - pick_valid and pick_num are held stable until pick_valid && pick_ready at a clock edge.
  - On that edge: set called_map[pick_num-1], increment called_count, drop pick_valid, go to IDLE.
  - enter_pulse during OFFER is not latched. It registers reject_pulse=1 with code 11, including on the handshake cycle itself.
- clear_called has priority over every other event in every state. On the next edge it:
  - zeros called_map and called_count;
  - drops pick_valid, aborting any pending offer;
  - suppresses reject_pulse;
  - goes to IDLE.
  - An enter_pulse in the same cycle as clear_called is discarded.
- called_count never exceeds MAX_NUM; duplicate detection guarantees this.
- When all_called is high, every in-range entry is rejected with code 10.
- reject_pulse is never high for two consecutive cycles from a single event.
- reject_pulse and pick_valid rising in the same cycle is impossible.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; every output is 0, including called_map, called_count, pick_num, reject_code and all_called.
- Release of rst_n takes effect synchronously, at the first rising clk edge after deassertion.
- Cycle numbering for an entry accepted in IDLE:
  - enter_pulse high in cycle 0.
  - Cycle 1: CHECK.
  - Cycle 2: pick_valid or reject_pulse is high. Latency is two edges.
- Handshake completing at the edge ending cycle n:
  - called_map, called_count and all_called are updated in cycle n+1.
  - pick_valid is low in cycle n+1.
  - An enter_pulse in cycle n+1 is accepted.
- Busy reject: enter_pulse in an OFFER cycle n gives reject_pulse with code 11 in cycle n+1.
- pick_ready held permanently high: a valid call is consumed in its first offer cycle. The next entry is accepted from cycle 3 relative to the original enter_pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then display_num=8'h07 with a 1-cycle enter_pulse and pick_ready=1:
  - cycle 2: pick_valid=1, pick_num=7;
  - cycle 3: called_map[6]=1, called_count=1.
- Enter 8'h00, 8'h26 and 8'h3A, with MAX_NUM=25: each gives reject_pulse with code 01 in its cycle 2; called_map is unchanged.
- Accept 8'h12, then enter 8'h12 again: reject_pulse with code 10; called_count stays 1.
- Hold pick_ready=0 after the valid entry 8'h05, then pulse enter with 8'h09:
  - reject code 11 on the next cycle;
  - pick_num stays 5;
  - raising pick_ready commits 5, not 9.
- Call all of 1..25:
  - all_called=1 and called_count=25;
  - entry 8'h25 is rejected with code 10;
  - clear_called zeros called_map and called_count and drops all_called.
- Assert clear_called during OFFER together with enter_pulse, then drop rst_n mid-OFFER in a separate run:
  - the clear run: pick_valid low next cycle, no reject_pulse, called_count=0.
  - the reset run: all outputs 0 immediately.
